// File: rtl/bsg_oddr_phy_pkg.sv
`default_nettype none
// ============================================================================
// bsg_oddr_phy_pkg : shared types and helpers for the half-rate ODDR PHY
// Rev 1.0
// ============================================================================
package bsg_oddr_phy_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_TRAIN = 2'd2
    } phy_state_e;

    // Never narrower than one bit, so a zero-length hold still has a counter.
    function automatic int hold_cnt_width(input int hold_cycles);
        return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
    endfunction

    function automatic logic [63:0] train_word(input logic [63:0] pat, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (((~pat) & mask) << w) | (pat & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_oddr_phy_gen_fifo.sv
`default_nettype none
// ============================================================================
// bsg_oddr_phy_gen_fifo : 2-entry valid/ready buffer, asynchronous reset
// Rev 1.0
// ============================================================================
module bsg_oddr_phy_gen_fifo #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_q [2];
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               en_q;
    logic               w_enq, w_deq;

    // en_q keeps ready_o low until the first edge after reset release.
    assign ready_o = en_q & (cnt_q != 2'd2);
    assign v_o     = (cnt_q != 2'd0);
    assign data_o  = mem_q[rptr_q];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    always_comb begin
        wptr_d = wptr_q ^ w_enq;
        rptr_d = rptr_q ^ w_deq;
        cnt_d  = cnt_q;
        if (w_enq && !w_deq) begin
            cnt_d = cnt_q + 2'd1;
        end else if (w_deq && !w_enq) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
            en_q   <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            en_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_oddr_phy_gen.sv
`default_nettype none
// ============================================================================
// bsg_oddr_phy_gen : half-rate ODDR output PHY with hold, idle fill and training
// Rev 1.0
// ============================================================================
module bsg_oddr_phy_gen
    import bsg_oddr_phy_pkg::*;
#(
    parameter int                 width_p         = 8,
    parameter bit                 center_clk_p    = 1'b1,
    parameter int                 hold_cycles_p   = 4,
    parameter logic [width_p-1:0] idle_pattern_p  = '0,
    parameter logic [width_p-1:0] train_pattern_p = width_p'(8'hA5)
) (
    input  logic                 clk_2x_i,
    input  logic                 reset_i,
    input  logic [2*width_p-1:0] data_i,
    input  logic                 v_i,
    output logic                 ready_o,
    input  logic                 train_i,
    output logic                 train_active_o,
    output logic [width_p-1:0]   data_r_o,
    output logic                 clk_r_o
);

    localparam int                   c_cnt_w      = hold_cnt_width(hold_cycles_p);
    localparam logic [c_cnt_w-1:0]   c_hold_last  =
        c_cnt_w'((hold_cycles_p == 0) ? 0 : hold_cycles_p - 1);
    localparam logic [63:0]          c_train_full = train_word(64'(train_pattern_p), width_p);
    localparam logic [2*width_p-1:0] c_train_word = c_train_full[2*width_p-1:0];
    localparam logic [2*width_p-1:0] c_idle_word  = {idle_pattern_p, idle_pattern_p};

    phy_state_e           state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 half_q, half_d;
    logic [width_p-1:0]   hi_q, hi_d;
    logic [width_p-1:0]   data_q, data_d;
    logic                 clk_q, clk_d;

    logic [2*width_p-1:0] w_fifo_data;
    logic                 w_fifo_v;
    logic                 w_pop;
    logic [2*width_p-1:0] w_word;

    bsg_oddr_phy_gen_fifo #(
        .width_p (2*width_p)
    ) u_fifo (
        .clk_i   (clk_2x_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_o  (w_fifo_data),
        .v_o     (w_fifo_v),
        .yumi_i  (w_pop)
    );

    always_ff @(posedge clk_2x_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            hi_q    <= '0;
            data_q  <= '0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            clk_q   <= clk_d;
        end
    end

    // Outside HOLD the mode is re-chosen only at word boundaries (half_q == 0).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == c_hold_last) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            default: begin
                half_d = ~half_q;
                if (!half_q) begin
                    state_d = train_i ? ST_TRAIN : ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        w_pop  = 1'b0;
        w_word = c_idle_word;
        data_d = idle_pattern_p;
        hi_d   = hi_q;
        clk_d  = 1'b0;
        if (state_q != ST_HOLD) begin
            if (!half_q) begin
                if (train_i) begin
                    w_word = c_train_word;
                end else if (w_fifo_v) begin
                    w_word = w_fifo_data;
                    w_pop  = 1'b1;
                end
                data_d = w_word[width_p-1:0];
                hi_d   = w_word[2*width_p-1:width_p];
                clk_d  = 1'b1;
            end else begin
                data_d = hi_q;
            end
        end
    end

    assign data_r_o       = data_q;
    assign train_active_o = (state_q == ST_TRAIN);

    generate
        if (center_clk_p) begin : g_center_clk
            logic clk_neg_q;
            always_ff @(negedge clk_2x_i or posedge reset_i) begin
                if (reset_i) begin
                    clk_neg_q <= 1'b0;
                end else begin
                    clk_neg_q <= clk_q;
                end
            end
            assign clk_r_o = clk_neg_q;
        end else begin : g_edge_clk
            assign clk_r_o = clk_q;
        end
    endgenerate

endmodule
`default_nettype wire
